// File: rtl/ov5640_capture_pkg.sv
// ov5640_pkg: shared definitions for the OV5640 capture front-end.
//   - cap_state_e     : capture FSM states (IDLE, ARM, ACTIVE)
//   - DEF_H_PIXELS    : default active pixels per line
//   - DEF_V_LINES     : default active lines per frame
//   - RGB565 field positions and a helper that assembles a pixel word
//     from the two sensor bytes (high byte first on the bus)
package ov5640_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2
    } cap_state_e;

    localparam int DEF_H_PIXELS = 800;
    localparam int DEF_V_LINES  = 600;

    localparam int WORD_W     = 16;
    localparam int PIX_CNT_W  = 12;
    localparam int LINE_CNT_W = 11;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // The sensor sends R[4:0],G[5:3] then G[2:0],B[4:0]; the fields are
    // placed explicitly so the byte order is visible at one point.
    function automatic logic [WORD_W-1:0] rgb565_pack(input logic [7:0] hi,
                                                      input logic [7:0] lo);
        logic [WORD_W-1:0] w;
        w              = '0;
        w[R_MSB:R_LSB] = hi[7:3];
        w[G_MSB:G_LSB] = {hi[2:0], lo[7:5]};
        w[B_MSB:B_LSB] = lo[4:0];
        return w;
    endfunction

endpackage

// File: rtl/ov5640_capture_if.sv
// ov5640_capture_if: write port toward the SDRAM write FIFO.
//   wfifo_full    : FIFO cannot accept a word this cycle (slave -> master)
//   wfifo_wr_en   : one-cycle write strobe             (master -> slave)
//   wfifo_wr_data : RGB565 word                        (master -> slave)
interface ov5640_capture_if;
    import ov5640_pkg::*;

    logic              wfifo_full;
    logic              wfifo_wr_en;
    logic [WORD_W-1:0] wfifo_wr_data;

    modport master (input wfifo_full, output wfifo_wr_en, output wfifo_wr_data);
    modport slave  (output wfifo_full, input wfifo_wr_en, input wfifo_wr_data);
endinterface

// File: rtl/ov5640_capture_packer.sv
// cam_byte_packer: registers the DVP inputs, detects vsync/href edges and
// pairs bytes into RGB565 words.
//   clk, rst          : pixel clock, sync active-high reset
//   cam_vsync/href/data : raw sensor inputs
//   word_valid, word  : a complete pixel is available this cycle
//   line_end, line_odd: registered href fell; line_odd = orphan byte pending
//   frame_rise/fall   : registered vsync rising / falling edge
module cam_byte_packer
    import ov5640_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              line_end,
    output logic              line_odd,
    output logic              frame_rise,
    output logic              frame_fall
);
    logic       vsync_p0, href_p0, vsync_p1, href_p1;
    logic [7:0] data_p0;
    logic [7:0] hi_byte_q;
    logic       phase_q, phase_d;

    // Stage p0: sample the sensor pins. Stage p1: previous copy for edges.
    // These keep sampling through reset so no false edge follows it.
    always_ff @(posedge clk) begin
        vsync_p0 <= cam_vsync;
        href_p0  <= cam_href;
        data_p0  <= cam_data;
        vsync_p1 <= vsync_p0;
        href_p1  <= href_p0;
    end

    always_comb begin
        phase_d = 1'b0;
        if (href_p0) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clk) begin
        if (href_p0 && !phase_q) begin
            hi_byte_q <= data_p0;
        end
    end

    assign word_valid = href_p0 & phase_q;
    assign word       = rgb565_pack(hi_byte_q, data_p0);
    assign line_end   = ~href_p0 & href_p1;
    // Phase is still 1 on the line_end cycle only if the last byte was a high byte.
    assign line_odd   = phase_q;
    assign frame_rise = vsync_p0 & ~vsync_p1;
    assign frame_fall = ~vsync_p0 & vsync_p1;
endmodule

// File: rtl/ov5640_capture.sv
// ov5640_capture: OV5640 DVP capture front-end feeding the SDRAM write FIFO.
//   clk, rst          : pixel clock, sync active-high reset
//   capture_en        : allow capture, sampled at frame start
//   cam_vsync/href/data : sensor DVP bus
//   wfifo             : FIFO write port (master side)
//   frame_start/done  : one-cycle frame boundary pulses
//   frame_cnt         : captured frames, wraps at 255
//   line_err, frame_err, overflow : sticky, cleared at frame_start
//   busy              : high while a frame is being captured
module ov5640_capture
    import ov5640_pkg::*;
#(
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int SKIP_FRAMES = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture_en,
    input  logic                    cam_vsync,
    input  logic                    cam_href,
    input  logic [7:0]              cam_data,
    ov5640_capture_if.master        wfifo,
    output logic                    frame_start,
    output logic                    frame_done,
    output logic [7:0]              frame_cnt,
    output logic                    line_err,
    output logic                    frame_err,
    output logic                    overflow,
    output logic                    busy
);
    localparam logic [PIX_CNT_W-1:0]  H_PIX_L = PIX_CNT_W'(H_PIXELS);
    localparam logic [LINE_CNT_W-1:0] V_LIN_L = LINE_CNT_W'(V_LINES);
    localparam logic [7:0]            SKIP_L  = 8'(SKIP_FRAMES);

    logic              word_valid, line_end, line_odd, frame_rise, frame_fall;
    logic [WORD_W-1:0] word;

    cam_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .word_valid (word_valid),
        .word       (word),
        .line_end   (line_end),
        .line_odd   (line_odd),
        .frame_rise (frame_rise),
        .frame_fall (frame_fall)
    );

    cap_state_e            state_q, state_d;
    logic [7:0]            skip_q, skip_d;
    logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d, line_cnt_eff;
    logic                  wr_en_q, wr_en_d;
    logic [WORD_W-1:0]     wr_data_q, wr_data_d;
    logic                  fs_q, fs_d, fd_q, fd_d;
    logic [7:0]            fcnt_q, fcnt_d;
    logic                  lerr_q, lerr_d, ferr_q, ferr_d, ovf_q, ovf_d;

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        line_cnt_eff = line_cnt_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        fs_d         = 1'b0;
        fd_d         = 1'b0;
        fcnt_d       = fcnt_q;
        lerr_d       = lerr_q;
        ferr_d       = ferr_q;
        ovf_d        = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (skip_q == 8'd0) begin
                    state_d = ARM;
                end else if (frame_rise) begin
                    skip_d = skip_q - 8'd1;
                end
            end
            ARM: begin
                if (frame_fall && capture_en) begin
                    fs_d       = 1'b1;
                    lerr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    ovf_d      = 1'b0;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                // A dropped word still counts so line geometry stays checkable.
                if (word_valid) begin
                    if (wfifo.wfifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = word;
                    end
                    if (pix_cnt_q != '1) begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
                if (line_end) begin
                    if (line_odd || (pix_cnt_q != H_PIX_L)) begin
                        lerr_d = 1'b1;
                    end
                    pix_cnt_d = '0;
                    if (line_cnt_q != '1) begin
                        line_cnt_eff = line_cnt_q + 1'b1;
                    end
                end
                line_cnt_d = line_cnt_eff;
                // Use the count including a line that ends on this same cycle.
                if (frame_rise) begin
                    fd_d   = 1'b1;
                    fcnt_d = fcnt_q + 8'd1;
                    if (line_cnt_eff != V_LIN_L) begin
                        ferr_d = 1'b1;
                    end
                    state_d = ARM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            skip_q     <= SKIP_L;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            fs_q       <= 1'b0;
            fd_q       <= 1'b0;
            fcnt_q     <= 8'd0;
            lerr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            fs_q       <= fs_d;
            fd_q       <= fd_d;
            fcnt_q     <= fcnt_d;
            lerr_q     <= lerr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign wfifo.wfifo_wr_en   = wr_en_q;
    assign wfifo.wfifo_wr_data = wr_data_q;
    assign frame_start         = fs_q;
    assign frame_done          = fd_q;
    assign frame_cnt           = fcnt_q;
    assign line_err            = lerr_q;
    assign frame_err           = ferr_q;
    assign overflow            = ovf_q;
    assign busy                = (state_q == ACTIVE);
endmodule

// File: tb/tb_ov5640_capture.sv
// Testbench for ov5640_capture with small geometry (4x3, skip 2).
// Frames are generated with random pixel bytes; a frame-level model decides
// which frames are captured and which words, flags and counts to expect.
module tb_ov5640_capture;
    localparam int H    = 4;
    localparam int V    = 3;
    localparam int SKIP = 2;

    logic       clk = 1'b0;
    logic       rst, capture_en, cam_vsync, cam_href;
    logic [7:0] cam_data;
    logic       frame_start, frame_done, line_err, frame_err, overflow, busy;
    logic [7:0] frame_cnt;

    ov5640_capture_if wf();

    ov5640_capture #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SKIP)) dut (
        .clk         (clk),
        .rst         (rst),
        .capture_en  (capture_en),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .wfifo       (wf.master),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] got_q[$];
    int          got_cyc[$];
    logic [15:0] exp_q[$];
    int          exp_cyc[$];
    int          fs_seen = 0;
    int          fd_seen = 0;

    // Frame-level model state
    int skip_left;
    int m_cnt;
    bit m_lerr, m_ferr, m_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wf.wfifo_wr_en === 1'b1) begin
            got_q.push_back(wf.wfifo_wr_data);
            got_cyc.push_back(cyc);
        end
        if (frame_start === 1'b1) fs_seen++;
        if (frame_done === 1'b1) fd_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one frame (vsync fall, lines, vsync rise, blanking), update the
    // model and compare the frame's results.
    task automatic send_frame(input int nlines, input int b0, input int b1, input int b2,
                              input int drop_pix, input int ce_off_line, input int rst_line,
                              input bit fixed);
        int         lb[3];
        logic [7:0] fixb[4];
        logic [7:0] b, hi;
        bit         captured, pend;
        int         pix, nmin;
        lb   = '{b0, b1, b2};
        fixb = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
        hi   = 8'h00;
        got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
        fs_seen = 0; fd_seen = 0;
        captured = (skip_left == 0) && (capture_en == 1'b1);
        if (captured) begin
            m_lerr = 0; m_ferr = 0; m_ovf = 0;
        end
        @(negedge clk);
        cam_vsync = 1'b0;
        wf.wfifo_full = 1'b0;
        repeat (3) @(negedge clk);
        pix = 0; pend = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int bi = 0; bi < lb[l]; bi++) begin
                @(negedge clk);
                if (rst_line == l && bi == 3) rst = 1'b1;
                if (rst_line == l && bi == 4) begin
                    rst = 1'b0;
                    n_tests++;
                    if ({wf.wfifo_wr_en, wf.wfifo_wr_data, frame_start, frame_done, frame_cnt,
                         line_err, frame_err, overflow, busy} !== '0) begin
                        n_fail++;
                        $display("FAIL midline_rst_outputs: got wr_en=%b data=%h fs=%b fd=%b cnt=%0d le=%b fe=%b ov=%b busy=%b want all 0",
                                 wf.wfifo_wr_en, wf.wfifo_wr_data, frame_start, frame_done, frame_cnt,
                                 line_err, frame_err, overflow, busy);
                    end
                    skip_left = SKIP; m_cnt = 0; m_lerr = 0; m_ferr = 0; m_ovf = 0;
                    captured = 0;
                    got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
                    fs_seen = 0; fd_seen = 0;
                end
                b = 8'($urandom);
                if (fixed && l == 0 && bi < 4) b = fixb[bi];
                cam_href = 1'b1;
                cam_data = b;
                wf.wfifo_full = pend;
                pend = 0;
                if (bi % 2 == 0) begin
                    hi = b;
                end else begin
                    if (pix == drop_pix) begin
                        pend = 1;
                        if (captured) m_ovf = 1;
                    end else if (captured) begin
                        exp_q.push_back({hi, b});
                        exp_cyc.push_back(cyc + 2);
                    end
                    pix++;
                end
            end
            if (captured && ((lb[l] % 2 != 0) || (lb[l] / 2 != H))) m_lerr = 1;
            if (ce_off_line == l) capture_en = 1'b0;
            repeat (4) begin
                @(negedge clk);
                cam_href = 1'b0;
                wf.wfifo_full = pend;
                pend = 0;
            end
        end
        if (captured && nlines != V) m_ferr = 1;
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        if (captured) m_cnt = (m_cnt + 1) % 256;
        else if (skip_left > 0) skip_left--;

        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL write_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL word_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
            n_tests++;
            if (got_cyc[i] != exp_cyc[i]) begin
                n_fail++;
                $display("FAIL word_latency[%0d]: got cycle %0d want %0d", i, got_cyc[i], exp_cyc[i]);
            end
        end
        n_tests++;
        if (fs_seen != int'(captured)) begin
            n_fail++;
            $display("FAIL frame_start_pulses: got %0d want %0d", fs_seen, int'(captured));
        end
        n_tests++;
        if (fd_seen != int'(captured)) begin
            n_fail++;
            $display("FAIL frame_done_pulses: got %0d want %0d", fd_seen, int'(captured));
        end
        n_tests++;
        if (frame_cnt !== 8'(m_cnt)) begin
            n_fail++;
            $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, m_cnt);
        end
        n_tests++;
        if ({line_err, frame_err, overflow} !== {m_lerr, m_ferr, m_ovf}) begin
            n_fail++;
            $display("FAIL sticky_flags: got le=%b fe=%b ov=%b want le=%b fe=%b ov=%b",
                     line_err, frame_err, overflow, m_lerr, m_ferr, m_ovf);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_frame: got %b want 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; capture_en = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0;
        cam_data = 8'h00; wf.wfifo_full = 1'b0;
        skip_left = SKIP; m_cnt = 0; m_lerr = 0; m_ferr = 0; m_ovf = 0;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({wf.wfifo_wr_en, wf.wfifo_wr_data, frame_start, frame_done, frame_cnt,
             line_err, frame_err, overflow, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr_en=%b data=%h cnt=%0d busy=%b want all 0",
                     wf.wfifo_wr_en, wf.wfifo_wr_data, frame_cnt, busy);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({wf.wfifo_wr_en, busy, frame_start} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got wr_en=%b busy=%b fs=%b want 0 0 0",
                     wf.wfifo_wr_en, busy, frame_start);
        end
    endtask

    task automatic test_skip_and_basic();
        send_frame(3, 8, 8, 8, -1, -1, -1, 0);
        n_tests++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL skip_frame1_writes: got %0d want 0", got_q.size()); end
        send_frame(3, 8, 8, 8, -1, -1, -1, 0);
        n_tests++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL skip_frame2_writes: got %0d want 0", got_q.size()); end
        send_frame(3, 8, 8, 8, -1, -1, -1, 1);
        n_tests++;
        if (got_q.size() != 12) begin n_fail++; $display("FAIL frame3_writes: got %0d want 12", got_q.size()); end
        n_tests++;
        if (got_q.size() < 2 || got_q[0] !== 16'hF81F || got_q[1] !== 16'h07E0) begin
            n_fail++;
            $display("FAIL byte_order: got %h %h want f81f 07e0",
                     (got_q.size() > 0) ? got_q[0] : 16'h0, (got_q.size() > 1) ? got_q[1] : 16'h0);
        end
        n_tests++;
        if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL frame3_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_line_frame_err();
        send_frame(3, 8, 7, 8, -1, -1, -1, 0);
        n_tests++;
        if (got_q.size() != 11 || line_err !== 1'b1 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_line: got writes=%0d le=%b fe=%b want 11 1 0", got_q.size(), line_err, frame_err);
        end
        send_frame(2, 8, 8, 0, -1, -1, -1, 0);
        n_tests++;
        if (line_err !== 1'b0 || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL short_frame: got le=%b fe=%b want 0 1", line_err, frame_err);
        end
        send_frame(3, 8, 8, 8, -1, -1, -1, 0);
        n_tests++;
        if (line_err !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got le=%b fe=%b want 0 0", line_err, frame_err);
        end
    endtask

    task automatic test_overflow();
        send_frame(3, 8, 8, 8, 4, -1, -1, 0);
        n_tests++;
        if (got_q.size() != 11 || overflow !== 1'b1 || line_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_drop: got writes=%0d ov=%b le=%b want 11 1 0", got_q.size(), overflow, line_err);
        end
    endtask

    task automatic test_capture_en();
        send_frame(3, 8, 8, 8, -1, 0, -1, 0);
        n_tests++;
        if (got_q.size() != 12 || fd_seen != 1) begin
            n_fail++;
            $display("FAIL ce_drop_current: got writes=%0d fd=%0d want 12 1", got_q.size(), fd_seen);
        end
        send_frame(3, 8, 8, 8, -1, -1, -1, 0);
        n_tests++;
        if (got_q.size() != 0 || fs_seen != 0) begin
            n_fail++;
            $display("FAIL ce_off_frame: got writes=%0d fs=%0d want 0 0", got_q.size(), fs_seen);
        end
        capture_en = 1'b1;
        send_frame(3, 8, 8, 8, -1, -1, -1, 0);
        n_tests++;
        if (got_q.size() != 12) begin n_fail++; $display("FAIL ce_resume: got %0d want 12", got_q.size()); end
    endtask

    task automatic test_reset_midline();
        send_frame(3, 8, 8, 8, -1, -1, 1, 0);
        send_frame(3, 8, 8, 8, -1, -1, -1, 0);
        n_tests++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_skip_reapplied: got %0d want 0", got_q.size()); end
        send_frame(3, 8, 8, 8, -1, -1, -1, 0);
        n_tests++;
        if (got_q.size() != 12 || frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL rst_recapture: got writes=%0d cnt=%0d want 12 1", got_q.size(), frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_skip_and_basic();
        test_line_frame_err();
        test_overflow();
        test_capture_en();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ov5640_capture.md
Name: ov5640_capture

Overview:
Camera capture front-end that sits directly upstream of the SDRAM write FIFO. It samples the OV5640 DVP byte stream (vsync/href/8-bit data) and packs byte pairs into RGB565 words. It drives the 16-bit wfifo write port with frame-aligned pixels and reports frame boundaries, so the SDRAM write-address logic can rewind on each frame start. It discards the first frames after reset while the sensor settles.

Parameters:
H_PIXELS, 800, pixels (16-bit words) per active line
V_LINES, 600, active lines per frame (800x600 = 480000 words)
SKIP_FRAMES, 10, complete frames discarded after reset before capture may begin

Ports:
clk  in  1  camera pixel clock; the block's only clock
rst  in  1  reset; the block has one clock, and reset is synchronous and active-high
capture_en  in  1  allow capture; sampled only at frame start
cam_vsync  in  1  sensor vsync; high = vertical blanking
cam_href  in  1  sensor href; high = valid bytes on cam_data
cam_data  in  8  sensor data byte; high byte of each pixel first
wfifo_full  in  1  write FIFO full
wfifo_wr_en  out  1  one-cycle write strobe
wfifo_wr_data  out  16  RGB565 word {first byte, second byte}
frame_start  out  1  one-cycle pulse when a captured frame begins
frame_done  out  1  one-cycle pulse when a captured frame ends
frame_cnt  out  8  captured-frame counter; wraps 255->0
line_err  out  1  sticky: a line had a pixel count other than H_PIXELS, or an odd byte count
frame_err  out  1  sticky: a frame had a line count other than V_LINES
overflow  out  1  sticky: a word was dropped because wfifo_full was high
busy  out  1  high while in ACTIVE

Behaviour:
- Input stage: cam_vsync, cam_href and cam_data are registered once. All decisions use the registered copies. Edges are detected against a second register of vsync/href.
- Reset: every output is 0, state IDLE, skip counter = SKIP_FRAMES, byte phase = 0. Reset mid-frame aborts the frame; no write is issued in the cycle after rst.
- States:
  - IDLE: count vsync rising edges. Once SKIP_FRAMES rising edges have been seen (immediately if SKIP_FRAMES = 0), go to ARM.
  - ARM: on a vsync falling edge with capture_en = 1, pulse frame_start and clear line_err, frame_err and overflow, then go to ACTIVE. With capture_en = 0, stay in ARM.
  - ACTIVE: pack pixels. On a vsync rising edge, pulse frame_done, increment frame_cnt, check the line count, then go to ARM.
- Packing:
  - Byte phase toggles on each registered href-high cycle and clears when href is low. Phase 0 stores the high byte.
  - Phase 1 forms the word. wfifo_wr_en and wfifo_wr_data are registered one cycle after the registered low byte is seen, so a pixel is written 2 clk edges after its low byte is on cam_data.
  - Writes occur only in ACTIVE. Outside ACTIVE, wfifo_wr_en stays 0.
- FIFO full: if wfifo_full = 1 in the cycle a word is formed, the word is dropped (no strobe) and overflow is set. The pixel counter still advances, to keep geometry checks valid.
- Line end (registered href falling edge, ACTIVE only):
  - If phase = 1, drop the orphan byte and set line_err.
  - If pix_cnt != H_PIXELS, set line_err.
  - Then clear pix_cnt and increment line_cnt.
  - pix_cnt saturates at 2^12-1 and line_cnt at 2^11-1; neither wraps.
- Frame end: if line_cnt != V_LINES, set frame_err. line_cnt clears at frame_start.
- capture_en deasserted mid-frame has no effect until the current frame completes; ARM then waits.
- frame_start and frame_done never coincide. A vsync rising edge in ARM is ignored.

Decomposition:
- Shared package ov5640_pkg: state enum (IDLE, ARM, ACTIVE), default geometry constants H_PIXELS/V_LINES, RGB565 field positions (R[15:11], G[10:5], B[4:0]).
- One sub-module, cam_byte_packer: input registers, edge detect, byte phase and word formation. It outputs word_valid/word/line_end/frame_rise/frame_fall.
- The top level holds the FSM, counters, error flags and the FIFO gating.

Test Plan:
- SKIP_FRAMES=2, H_PIXELS=4, V_LINES=3, capture_en=1, three synthetic frames -> zero writes in frames 1-2. Frame 3 gives exactly 12 wfifo_wr_en strobes, one frame_start, one frame_done, frame_cnt=1, no error flags.
- Byte order: bytes 0xF8,0x1F, then 0x07,0xE0 -> wfifo_wr_data 0xF81F, then 0x07E0, each strobe 2 edges after its low byte.
- Line of 7 bytes (3.5 pixels) -> 3 writes, orphan byte dropped, line_err=1. A frame of 2 lines -> frame_err=1. Both flags clear at the next frame_start.
- wfifo_full=1 for the cycle of pixel 5 of a 12-pixel frame -> 11 writes, pixel 5 absent, overflow=1, line_err=0.
- capture_en dropped after line 1 -> the current frame still yields all 12 writes and frame_done. The next frame yields no frame_start and no writes; re-asserting capture_en resumes at the following frame.
- rst pulsed mid-line -> all outputs 0 the next cycle, state IDLE, SKIP_FRAMES re-applied before the next capture.
